// File: rtl/lin_regr_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lin_regr_frame_ctrl
// Purpose  : Per-frame sequencer for the linear-regression datapath: forwards
//            mask pixels, issues tabulate, waits for the fit under a watchdog
//            and publishes the latched result. Optional y clip: LIN_REGR_YCLIP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lin_regr_frame_ctrl #(
  parameter int unsigned MIN_POINTS     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned Y_LIMIT        = 317
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [10:0]        x_in,
  input  logic [9:0]         y_in,
  input  logic               pix_valid_in,
  input  logic               frame_end_in,
  output logic [10:0]        regr_x_out,
  output logic [9:0]         regr_y_out,
  output logic               regr_valid_out,
  output logic               regr_tabulate_out,
  output logic               regr_rst_out,
  input  logic signed [17:0] regr_a_in,
  input  logic signed [24:0] regr_b_in,
  input  logic               regr_valid_in,
  output logic signed [17:0] a_out,
  output logic signed [24:0] b_out,
  output logic [20:0]        count_out,
  output logic               result_valid_out,
  output logic               fit_ok_out,
  output logic               timeout_out,
  output logic               overrun_out,
  output logic [15:0]        drop_count_out
);

  localparam int unsigned c_TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [20:0] c_MIN_POINTS = 21'(MIN_POINTS);
  localparam int unsigned c_YLIM_CLAMP = (Y_LIMIT > 1024) ? 1024 : Y_LIMIT;
  localparam logic [10:0] c_Y_LIMIT    = 11'(c_YLIM_CLAMP);
`ifdef LIN_REGR_YCLIP_EN
  localparam bit c_YCLIP_EN = 1'b1;
`else
  localparam bit c_YCLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_TAB     = 2'd1,
    S_WAIT    = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  state_t            r_state, w_state_nx;
  logic [20:0]       r_count, w_count_nx;
  logic [c_TW-1:0]   r_wait_cnt, w_wait_nx;
  logic              r_overrun, w_overrun_nx;

  logic              w_pix_ok, w_publish;
  logic [10:0]       w_x_nx;
  logic [9:0]        w_y_nx;
  logic              w_pix_vld_nx, w_tab_nx, w_dp_rst_nx;
  logic signed [17:0] w_a_nx;
  logic signed [24:0] w_b_nx;
  logic [20:0]       w_cnt_out_nx;
  logic              w_res_vld_nx, w_fit_ok_nx, w_to_nx, w_ovr_out_nx;
  logic [15:0]       w_drop_nx;

  assign w_pix_ok = pix_valid_in && (!c_YCLIP_EN || ({1'b0, y_in} < c_Y_LIMIT));

  always_comb begin
    w_state_nx   = r_state;
    w_count_nx   = r_count;
    w_wait_nx    = r_wait_cnt;
    w_overrun_nx = r_overrun;
    w_drop_nx    = drop_count_out;
    w_x_nx       = regr_x_out;
    w_y_nx       = regr_y_out;
    w_pix_vld_nx = 1'b0;
    w_tab_nx     = 1'b0;
    w_dp_rst_nx  = 1'b0;
    w_a_nx       = a_out;
    w_b_nx       = b_out;
    w_cnt_out_nx = count_out;
    w_res_vld_nx = 1'b0;
    w_fit_ok_nx  = fit_ok_out;
    w_to_nx      = timeout_out;
    w_ovr_out_nx = overrun_out;
    w_publish    = 1'b0;

    case (r_state)
      S_COLLECT: begin
        if (w_pix_ok) begin
          w_x_nx       = x_in;
          w_y_nx       = y_in;
          w_pix_vld_nx = 1'b1;
          if (r_count != '1) w_count_nx = r_count + 21'd1;
        end
        if (frame_end_in) w_state_nx = S_TAB;
      end
      S_TAB: begin
        if (r_count != '0) begin
          w_tab_nx   = 1'b1;
          w_wait_nx  = '0;
          w_state_nx = S_WAIT;
        end else begin
          w_publish   = 1'b1;
          w_a_nx      = '0;
          w_b_nx      = '0;
          w_fit_ok_nx = 1'b0;
          w_to_nx     = 1'b0;
          w_state_nx  = S_PUBLISH;
        end
      end
      S_WAIT: begin
        // A result landing on the final watchdog cycle takes priority
        if (regr_valid_in) begin
          w_publish   = 1'b1;
          w_a_nx      = regr_a_in;
          w_b_nx      = regr_b_in;
          w_fit_ok_nx = (r_count >= c_MIN_POINTS);
          w_to_nx     = 1'b0;
          w_state_nx  = S_PUBLISH;
        end else if (r_wait_cnt == c_TO_LAST) begin
          w_publish   = 1'b1;
          w_a_nx      = '0;
          w_b_nx      = '0;
          w_fit_ok_nx = 1'b0;
          w_to_nx     = 1'b1;
          w_dp_rst_nx = 1'b1;
          w_state_nx  = S_PUBLISH;
        end else begin
          w_wait_nx = r_wait_cnt + 1'b1;
        end
      end
      default: begin
        w_count_nx   = '0;
        w_overrun_nx = 1'b0;
        w_state_nx   = S_COLLECT;
      end
    endcase

    // Busy states drop pixels and only remember a premature frame end
    if (r_state != S_COLLECT) begin
      if (w_pix_ok && (drop_count_out != '1)) w_drop_nx = drop_count_out + 16'd1;
      if (frame_end_in) w_overrun_nx = 1'b1;
    end

    if (w_publish) begin
      w_res_vld_nx = 1'b1;
      w_cnt_out_nx = r_count;
      w_ovr_out_nx = r_overrun | frame_end_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state           <= S_COLLECT;
      r_count           <= '0;
      r_wait_cnt        <= '0;
      r_overrun         <= 1'b0;
      regr_x_out        <= '0;
      regr_y_out        <= '0;
      regr_valid_out    <= 1'b0;
      regr_tabulate_out <= 1'b0;
      regr_rst_out      <= 1'b1;
      a_out             <= '0;
      b_out             <= '0;
      count_out         <= '0;
      result_valid_out  <= 1'b0;
      fit_ok_out        <= 1'b0;
      timeout_out       <= 1'b0;
      overrun_out       <= 1'b0;
      drop_count_out    <= '0;
    end else begin
      r_state           <= w_state_nx;
      r_count           <= w_count_nx;
      r_wait_cnt        <= w_wait_nx;
      r_overrun         <= w_overrun_nx;
      regr_x_out        <= w_x_nx;
      regr_y_out        <= w_y_nx;
      regr_valid_out    <= w_pix_vld_nx;
      regr_tabulate_out <= w_tab_nx;
      regr_rst_out      <= w_dp_rst_nx;
      a_out             <= w_a_nx;
      b_out             <= w_b_nx;
      count_out         <= w_cnt_out_nx;
      result_valid_out  <= w_res_vld_nx;
      fit_ok_out        <= w_fit_ok_nx;
      timeout_out       <= w_to_nx;
      overrun_out       <= w_ovr_out_nx;
      drop_count_out    <= w_drop_nx;
    end
  end

endmodule
`default_nettype wire

// File: doc/lin_regr_frame_ctrl.md
Name: lin_regr_frame_ctrl

Overview:
- Per-frame sequencer for the linear-regression datapath.
- Forwards qualified mask pixels (x,y) into the regression unit and counts them.
- At end of frame, issues the single tabulate pulse and waits for the fit with a timeout watchdog. Resets the datapath if the fit never arrives.
- Publishes the latched fit coefficients, point count and quality flags to downstream consumers (tracker/renderer).

Parameters:
- MIN_POINTS, 16: fewer accepted points than this gives fit_ok_out=0. The fit is still computed.
- TIMEOUT_CYCLES, 4096: maximum cycles spent in WAIT before a timeout is declared.
- Y_LIMIT, 317: pixels with y_in >= Y_LIMIT are rejected (only when LIN_REGR_YCLIP_EN is defined).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous reset, active-high
- x_in  in  11  pixel column
- y_in  in  10  pixel row
- pix_valid_in  in  1  pixel belongs to mask
- frame_end_in  in  1  one-cycle end-of-frame strobe
- regr_x_out  out  11  x to datapath
- regr_y_out  out  10  y to datapath
- regr_valid_out  out  1  pixel strobe to datapath
- regr_tabulate_out  out  1  tabulate strobe to datapath
- regr_rst_out  out  1  synchronous reset to datapath
- regr_a_in  in  18 signed  datapath intercept (x8 scaled)
- regr_b_in  in  25 signed  datapath slope (x1024 scaled)
- regr_valid_in  in  1  datapath result strobe
- a_out  out  18 signed  latched intercept
- b_out  out  25 signed  latched slope
- count_out  out  21  points accepted in the frame
- result_valid_out  out  1  one-cycle result strobe
- fit_ok_out  out  1  count_out >= MIN_POINTS and no timeout
- timeout_out  out  1  the fit timed out
- overrun_out  out  1  frame_end_in arrived while busy
- drop_count_out  out  16  saturating count of pixels dropped while busy

Behaviour:
- Clock and reset:
  - Single clock, clk_in.
  - rst_in is asynchronous and active-high.
  - All outputs are registered.
- Reset values:
  - All outputs are 0, except regr_rst_out=1.
  - regr_rst_out deasserts on the first clk_in edge after rst_in falls.
  - Internal count and state go to COLLECT.
  - drop_count_out clears only on rst_in.
- COLLECT state:
  - Each pix_valid_in (passing the optional clip) is driven onto regr_x_out/regr_y_out with regr_valid_out=1 one cycle later. The accepted count increments (21-bit, saturating).
  - On frame_end_in, go to TAB.
  - If pix_valid_in coincides with frame_end_in, that pixel is forwarded and counted first.
- TAB state:
  - If count>0: regr_tabulate_out=1 for exactly one cycle, visible 2 cycles after the frame_end_in cycle. Go to WAIT.
  - regr_valid_out and regr_tabulate_out are never high in the same cycle.
  - If count==0: no tabulate is issued. Go to PUBLISH with a_out=b_out=0, fit_ok_out=0.
- WAIT state:
  - A cycle counter counts up to TIMEOUT_CYCLES.
  - On regr_valid_in: latch regr_a_in/regr_b_in. Go to PUBLISH.
  - On timeout: a_out=b_out=0, timeout_out=1, fit_ok_out=0, regr_rst_out=1 for one cycle. Go to PUBLISH.
  - If regr_valid_in arrives on the same cycle the timeout would fire, the result wins.
- PUBLISH state:
  - result_valid_out=1 for one cycle.
  - count_out, fit_ok_out, timeout_out and overrun_out update that cycle and are held until the next PUBLISH.
  - Clear the accepted count and the overrun latch. Go to COLLECT.
  - Latency from regr_valid_in to result_valid_out is 1 cycle.
- Busy (TAB/WAIT/PUBLISH):
  - pix_valid_in is not forwarded; drop_count_out increments, saturating at 65535.
  - frame_end_in sets the overrun latch and is otherwise ignored; it does not start a new tabulate.
- Stray inputs: regr_valid_in in COLLECT is ignored.
- Reset mid-operation: all state is abandoned immediately and regr_rst_out asserts, so the datapath accumulators are cleared.

Optional Feature:
- Macro LIN_REGR_YCLIP_EN.
- Defined: pixels with y_in >= Y_LIMIT are neither forwarded nor counted, and are not added to drop_count_out.
- Undefined: every pix_valid_in in COLLECT is accepted; Y_LIMIT is unused.

Test Plan:
- 20 pixels (x=0..19, y=2x+5), then frame_end at cycle T, with a datapath model returning a=40, b=2048 after 70 cycles:
  - regr_tabulate_out is high only at T+2.
  - result_valid_out fires 1 cycle after regr_valid_in, with a_out=40, b_out=2048, count_out=20, fit_ok_out=1.
- 5 pixels, then frame_end: tabulate is issued, count_out=5, fit_ok_out=0, timeout_out=0.
- frame_end with no pixels: no tabulate; result_valid_out at T+2 with count_out=0, a_out=b_out=0.
- Datapath never responds, TIMEOUT_CYCLES=64:
  - timeout_out=1 and a one-cycle regr_rst_out pulse, 64 cycles after tabulate.
  - The next frame of 16 pixels then fits normally with timeout_out=0.
- 3 pixels plus 1 frame_end during WAIT: drop_count_out=3, overrun_out=1 in that result; the following frame shows overrun_out=0.
- LIN_REGR_YCLIP_EN with y_in in {316,317,400}: only y=316 is forwarded, count_out=1.
  - Without the macro, all three are forwarded, count_out=3.
  - rst_in asserted mid-WAIT: outputs are 0 and regr_rst_out=1 asynchronously.
